// File: rtl/rv32_pkg.sv
// Shared definitions for the instruction fetch front end: reset/NOP
// constants, fetch FSM encoding and the buffered {inst, pc} entry type.
package rv32_pkg;

  localparam logic [31:0] RV_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] RV_NOP_INST  = 32'h0000_0013;
  localparam int          FETCH_DEPTH  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry {inst, pc} FIFO between the instruction memory response and
// decode. Flush wins over push and pop; push into a full buffer and pop
// from an empty one are ignored.
module fetch_buf
  import rv32_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  fetch_entry_t i_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic [1:0]   o_count,
  output logic [31:0]  o_head_inst,
  output logic [31:0]  o_head_pc
);

  fetch_entry_t r_mem [FETCH_DEPTH];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_do_push;
  logic         w_do_pop;

  assign w_do_push = i_push && !i_flush && (r_count != 2'd2);
  assign w_do_pop  = i_pop  && !i_flush && (r_count != 2'd0);

  // Each slot captures the incoming entry when the write pointer selects it.
  for (genvar gi = 0; gi < FETCH_DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_mem[gi] <= '0;
      end else if (w_do_push && (r_wr_ptr == gi[0])) begin
        r_mem[gi] <= i_entry;
      end
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  assign o_count     = r_count;
  assign o_head_inst = r_mem[r_rd_ptr].inst;
  assign o_head_pc   = r_mem[r_rd_ptr].pc;

endmodule

// File: rtl/fetch_ctl.sv
// Instruction fetch controller: issues word fetches, keeps at most two
// instructions outstanding (buffered plus in flight), and hands them to
// decode in order. An execute-stage redirect discards everything queued.
// A response arriving into an empty buffer is forwarded to decode in the
// same cycle, giving one cycle from imem_req to inst_valid.
module fetch_ctl
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RV_RESET_PC,
  parameter logic [31:0] NOP_INST = RV_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        pc_sel,
  input  logic [31:0] alu_target,
  input  logic        dec_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        misalign
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [31:0]  r_pc;
  logic         r_inflight;
  logic [31:0]  r_inflight_pc;

  logic         w_req;
  logic [1:0]   w_count;
  logic [1:0]   w_occupancy;
  logic         w_issue_ok;
  logic         w_fifo_empty;
  logic         w_bypass;
  logic         w_push;
  logic         w_pop;
  logic [31:0]  w_head_inst;
  logic [31:0]  w_head_pc;
  fetch_entry_t w_entry;

  // Outstanding work is what is buffered plus what memory still owes us.
  assign w_occupancy  = w_count + {1'b0, r_inflight};
  assign w_issue_ok   = (w_occupancy < 2'd2) && !pc_sel;
  assign w_fifo_empty = (w_count == 2'd0);

  // A response landing in an empty buffer goes straight to decode, except
  // during a redirect, when it belongs to the abandoned path.
  assign w_bypass = w_fifo_empty && r_inflight && !pc_sel;
  assign w_pop    = !w_fifo_empty && dec_ready;
  assign w_push   = r_inflight && !pc_sel && !(w_bypass && dec_ready);
  assign w_entry  = '{inst: imem_rdata, pc: r_inflight_pc};

  fetch_buf u_buf (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_entry     (w_entry),
    .i_pop       (w_pop),
    .i_flush     (pc_sel),
    .o_count     (w_count),
    .o_head_inst (w_head_inst),
    .o_head_pc   (w_head_pc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  // Next state and request issue; a redirect always lands in FETCH.
  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    case (r_state)
      ST_IDLE: w_state_next = ST_FETCH;
      ST_FETCH, ST_HOLD: begin
        if (w_issue_ok) begin
          w_req        = 1'b1;
          w_state_next = ST_FETCH;
        end else begin
          w_state_next = ST_HOLD;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (pc_sel) w_state_next = ST_FETCH;
  end

  // Program counter and in-flight tracking; a redirect kills the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_req;
      if (w_req) r_inflight_pc <= r_pc;
      if (pc_sel)     r_pc <= word_align(alu_target);
      else if (w_req) r_pc <= r_pc + 32'd4;
    end
  end

  // Decode-side presentation: buffer head first, else the forwarded response.
  always_comb begin
    inst       = NOP_INST;
    inst_pc    = 32'h0000_0000;
    inst_valid = 1'b0;
    if (!w_fifo_empty) begin
      inst       = w_head_inst;
      inst_pc    = w_head_pc;
      inst_valid = 1'b1;
    end else if (w_bypass) begin
      inst       = imem_rdata;
      inst_pc    = r_inflight_pc;
      inst_valid = 1'b1;
    end
  end

  assign imem_addr = r_pc;
  assign imem_req  = w_req;
  // Held low while reset is asserted, independent of the redirect inputs.
  assign misalign  = rst & pc_sel & (alu_target[1:0] != 2'b00);

endmodule
